// File: rtl/fpu_div_exp_pkg.sv
// Shared types and constants for the divide exponent sequencer.
// Bias, iteration count and overflow limits for double and single precision.
package fpu_div_exp_pkg;

  typedef enum logic [2:0] {
    IDLE,
    EXP,
    ITER,
    ADJ,
    RND,
    DONE
  } state_t;

  localparam logic [12:0] BIAS_DBL = 13'd1023;
  localparam logic [12:0] BIAS_SNG = 13'd127;
  localparam logic [5:0]  ITER_DBL = 6'd55;
  localparam logic [5:0]  ITER_SNG = 6'd26;
  localparam logic [12:0] EMAX_DBL = 13'd2047;
  localparam logic [12:0] EMAX_SNG = 13'd255;

endpackage

// File: rtl/fpu_div_exp_arith.sv
// Combinational exponent arithmetic for the divide sequencer: quotient exponent,
// normalization/underflow adjust and rounding/overflow result selection.
module fpu_div_exp_arith
  import fpu_div_exp_pkg::*;
(
  input  logic        dbl,
  input  logic [10:0] exp1,
  input  logic [10:0] exp2,
  input  logic [5:0]  ld0_1,
  input  logic [5:0]  ld0_2,
  input  logic [12:0] e_cur,
  input  logic        qmsb,
  input  logic        rnd_cout,
  input  logic        uf,
  input  logic        to_0,
  output logic [12:0] e_exp,
  output logic [12:0] e_adj,
  output logic        adj_uf,
  output logic [5:0]  adj_shift,
  output logic        rnd_of,
  output logic [10:0] rnd_exp
);

  logic [12:0] x1;
  logic [12:0] x2;
  logic [12:0] diff;
  logic [12:0] e_rnd;
  logic [12:0] emax;

  always_comb begin
    // Single precision keeps its 8-bit exponent in the top bits of the field.
    x1 = dbl ? {2'b00, exp1} : {5'b00000, exp1[10:3]};
    x2 = dbl ? {2'b00, exp2} : {5'b00000, exp2[10:3]};
    e_exp = (x1 - {7'b0, ld0_1}) - (x2 - {7'b0, ld0_2}) + (dbl ? BIAS_DBL : BIAS_SNG);

    e_adj = e_cur - {12'b0, ~qmsb};
    adj_uf = ($signed(e_adj) <= $signed(13'sd0));
    diff = 13'd1 - e_adj;
    adj_shift = 6'd0;
    if (adj_uf) adj_shift = (diff > 13'd63) ? 6'd63 : diff[5:0];

    // Underflow takes priority; overflow is judged on the rounded exponent.
    e_rnd = e_cur + {12'b0, rnd_cout};
    emax = dbl ? EMAX_DBL : EMAX_SNG;
    rnd_of = !uf && ($signed(e_rnd) >= $signed(emax));
    if (uf)
      rnd_exp = {10'b0, rnd_cout};
    else if (rnd_of)
      rnd_exp = dbl ? (to_0 ? 11'h7FE : 11'h7FF) : (to_0 ? 11'h0FE : 11'h0FF);
    else
      rnd_exp = dbl ? e_rnd[10:0] : {3'b000, e_rnd[7:0]};
  end

endmodule

// File: rtl/fpu_div_exp_seq.sv
// Divide exponent sequencer: captures operand exponents, paces the fraction
// divider, applies normalization/rounding corrections and hands back the result.
module fpu_div_exp_seq
  import fpu_div_exp_pkg::*;
(
  input  logic        rclk,
  input  logic        reset,
  input  logic        in_vld,
  output logic        in_rdy,
  input  logic        in_dblop,
  input  logic [10:0] in_exp1,
  input  logic [10:0] in_exp2,
  input  logic [5:0]  in_ld0_1,
  input  logic [5:0]  in_ld0_2,
  input  logic        in_to_0,
  input  logic        flush,
  output logic        div_step,
  input  logic        frac_qmsb,
  input  logic        frac_rnd_cout,
  output logic [5:0]  denorm_shift,
  output logic        out_vld,
  input  logic        out_rdy,
  output logic [10:0] out_exp,
  output logic        out_of,
  output logic        out_uf
);

  state_t      state, state_nx;
  logic        dbl_r, to0_r, uf_r;
  logic [10:0] e1_r, e2_r;
  logic [5:0]  ld1_r, ld2_r, cnt;
  logic [12:0] e_r, e_exp, e_adj;
  logic        adj_uf, rnd_of;
  logic [5:0]  adj_shift;
  logic [10:0] rnd_exp;

  fpu_div_exp_arith u_arith (
    .dbl       (dbl_r),
    .exp1      (e1_r),
    .exp2      (e2_r),
    .ld0_1     (ld1_r),
    .ld0_2     (ld2_r),
    .e_cur     (e_r),
    .qmsb      (frac_qmsb),
    .rnd_cout  (frac_rnd_cout),
    .uf        (uf_r),
    .to_0      (to0_r),
    .e_exp     (e_exp),
    .e_adj     (e_adj),
    .adj_uf    (adj_uf),
    .adj_shift (adj_shift),
    .rnd_of    (rnd_of),
    .rnd_exp   (rnd_exp)
  );

  // Flush suppresses the divider strobe in the very cycle it is raised.
  assign in_rdy   = (state == IDLE);
  assign div_step = (state == ITER) && !flush;
  assign out_vld  = (state == DONE);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (in_vld) state_nx = EXP;
      EXP:  state_nx = ITER;
      ITER: if (cnt == 6'd0) state_nx = ADJ;
      ADJ:  state_nx = RND;
      RND:  state_nx = DONE;
      DONE: if (out_rdy) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (flush) state_nx = IDLE;
  end

  // Result registers keep their last value until the next operation rewrites them.
  always_ff @(posedge rclk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      dbl_r        <= 1'b0;
      to0_r        <= 1'b0;
      uf_r         <= 1'b0;
      e1_r         <= 11'd0;
      e2_r         <= 11'd0;
      ld1_r        <= 6'd0;
      ld2_r        <= 6'd0;
      cnt          <= 6'd0;
      e_r          <= 13'd0;
      denorm_shift <= 6'd0;
      out_exp      <= 11'd0;
      out_of       <= 1'b0;
      out_uf       <= 1'b0;
    end else begin
      state <= state_nx;
      if (!flush) begin
        case (state)
          IDLE: if (in_vld) begin
            dbl_r <= in_dblop;
            to0_r <= in_to_0;
            e1_r  <= in_exp1;
            e2_r  <= in_exp2;
            ld1_r <= in_ld0_1;
            ld2_r <= in_ld0_2;
          end
          EXP: begin
            e_r <= e_exp;
            cnt <= dbl_r ? (ITER_DBL - 6'd1) : (ITER_SNG - 6'd1);
          end
          ITER: if (cnt != 6'd0) cnt <= cnt - 6'd1;
          ADJ: begin
            e_r          <= e_adj;
            uf_r         <= adj_uf;
            denorm_shift <= adj_shift;
          end
          RND: begin
            out_exp <= rnd_exp;
            out_of  <= rnd_of;
            out_uf  <= uf_r;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpu_div_exp_seq.sv
// Directed bench for fpu_div_exp_seq: exponent results, latency, step count,
// flush, backpressure and asynchronous reset behaviour.
module tb_fpu_div_exp_seq;

  logic        rclk = 1'b0;
  logic        reset, inVld, inDblop, inTo0, flush, fracQmsb, fracRndCout, outRdy;
  logic [10:0] inExp1, inExp2;
  logic [5:0]  inLd01, inLd02;
  logic        inRdy, divStep, outVld, outOf, outUf;
  logic [5:0]  denormShift;
  logic [10:0] outExp;

  int assertCount = 0;
  int failCount   = 0;

  always #5 rclk = ~rclk;

  fpu_div_exp_seq dut (
    .rclk          (rclk),
    .reset         (reset),
    .in_vld        (inVld),
    .in_rdy        (inRdy),
    .in_dblop      (inDblop),
    .in_exp1       (inExp1),
    .in_exp2       (inExp2),
    .in_ld0_1      (inLd01),
    .in_ld0_2      (inLd02),
    .in_to_0       (inTo0),
    .flush         (flush),
    .div_step      (divStep),
    .frac_qmsb     (fracQmsb),
    .frac_rnd_cout (fracRndCout),
    .denorm_shift  (denormShift),
    .out_vld       (outVld),
    .out_rdy       (outRdy),
    .out_exp       (outExp),
    .out_of        (outOf),
    .out_uf        (outUf)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic stepCycle();
    @(posedge rclk);
    #1;
  endtask

  task automatic setOperands(input logic dbl, input logic [10:0] e1, input logic [10:0] e2,
                             input logic [5:0] l1, input logic [5:0] l2, input logic to0,
                             input logic qmsb, input logic cout);
    inDblop = dbl; inExp1 = e1; inExp2 = e2; inLd01 = l1; inLd02 = l2;
    inTo0 = to0; fracQmsb = qmsb; fracRndCout = cout;
  endtask

  // Accept one operation, then count cycles (1 = EXP) and divider strobes until out_vld.
  task automatic applyStimulus(output int lat, output int nstep);
    int waitCnt;
    waitCnt = 0;
    while (!inRdy && waitCnt < 100) begin
      stepCycle();
      waitCnt++;
    end
    inVld = 1'b1;
    stepCycle();
    inVld = 1'b0;
    lat = 1;
    nstep = 0;
    while (!outVld && lat < 200) begin
      if (divStep) nstep++;
      stepCycle();
      lat++;
    end
    if (!outVld) checkOutput("timeout_out_vld", 0, 1);
  endtask

  task automatic releaseResult(input string name);
    outRdy = 1'b1;
    stepCycle();
    outRdy = 1'b0;
    checkOutput({name, "_in_rdy_after"}, inRdy, 1);
    checkOutput({name, "_out_vld_after"}, outVld, 0);
  endtask

  task automatic runCase(input string name, input logic dbl, input logic [10:0] e1, input logic [10:0] e2,
                         input logic [5:0] l1, input logic [5:0] l2, input logic to0, input logic qmsb,
                         input logic cout, input logic [10:0] expE, input logic expOf, input logic expUf,
                         input logic [5:0] expShift);
    int lat, nstep;
    setOperands(dbl, e1, e2, l1, l2, to0, qmsb, cout);
    applyStimulus(lat, nstep);
    checkOutput({name, "_latency"}, lat, dbl ? 59 : 30);
    checkOutput({name, "_steps"}, nstep, dbl ? 55 : 26);
    checkOutput({name, "_exp"}, outExp, expE);
    checkOutput({name, "_of"}, outOf, expOf);
    checkOutput({name, "_uf"}, outUf, expUf);
    checkOutput({name, "_shift"}, denormShift, expShift);
    checkOutput({name, "_in_rdy_done"}, inRdy, 0);
    releaseResult(name);
  endtask

  initial begin
    int lat, nstep, changes, vldSeen;
    reset = 1'b1; inVld = 1'b0; flush = 1'b0; outRdy = 1'b0;
    setOperands(1'b0, 11'd0, 11'd0, 6'd0, 6'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) stepCycle();
    checkOutput("rst_in_rdy", inRdy, 1);
    checkOutput("rst_div_step", divStep, 0);
    checkOutput("rst_out_vld", outVld, 0);
    checkOutput("rst_out_exp", outExp, 0);
    checkOutput("rst_flags", {outOf, outUf}, 0);
    checkOutput("rst_shift", denormShift, 0);
    reset = 1'b0;
    stepCycle();

    runCase("dbl_unity",  1, 11'h3FF, 11'h3FF, 0, 0, 0, 1, 0, 11'h3FF, 0, 0, 0);
    runCase("dbl_qmsb0",  1, 11'h3FF, 11'h3FF, 0, 0, 0, 0, 0, 11'h3FE, 0, 0, 0);
    runCase("sng_basic",  0, 11'h400, 11'h3F8, 0, 0, 0, 1, 0, 11'h080, 0, 0, 0);
    runCase("sng_q0_c1",  0, 11'h400, 11'h3F8, 0, 0, 0, 0, 1, 11'h080, 0, 0, 0);
    runCase("dbl_ld0",    1, 11'h3FF, 11'h3FF, 5, 2, 0, 1, 0, 11'h3FC, 0, 0, 0);
    runCase("dbl_of_inf", 1, 11'h7FE, 11'h001, 0, 0, 0, 1, 0, 11'h7FF, 1, 0, 0);
    runCase("dbl_of_max", 1, 11'h7FE, 11'h001, 0, 0, 1, 1, 0, 11'h7FE, 1, 0, 0);
    runCase("dbl_uf_big", 1, 11'h001, 11'h7FE, 0, 0, 0, 1, 0, 11'h000, 0, 1, 63);
    runCase("dbl_rnd_of", 1, 11'h7FE, 11'h3FF, 0, 0, 0, 1, 1, 11'h7FF, 1, 0, 0);
    runCase("dbl_uf_e0",  1, 11'h001, 11'h400, 0, 0, 0, 1, 1, 11'h001, 0, 1, 1);

    // Asynchronous reset in the middle of ITER, with nonzero results still held.
    setOperands(1, 11'h3FF, 11'h3FF, 0, 0, 0, 1, 0);
    inVld = 1'b1;
    stepCycle();
    inVld = 1'b0;
    repeat (15) stepCycle();
    checkOutput("rstmid_in_iter", divStep, 1);
    reset = 1'b1;
    #1;
    checkOutput("rstmid_in_rdy", inRdy, 1);
    checkOutput("rstmid_div_step", divStep, 0);
    checkOutput("rstmid_out_exp", outExp, 0);
    checkOutput("rstmid_uf", outUf, 0);
    checkOutput("rstmid_shift", denormShift, 0);
    stepCycle();
    reset = 1'b0;
    vldSeen = 0;
    repeat (80) begin
      stepCycle();
      if (outVld) vldSeen++;
    end
    checkOutput("rstmid_no_vld", vldSeen, 0);

    // Flush during ITER aborts the operation.
    setOperands(1, 11'h3FF, 11'h3FF, 0, 0, 0, 1, 0);
    inVld = 1'b1;
    stepCycle();
    inVld = 1'b0;
    repeat (11) stepCycle();
    checkOutput("flush_pre_step", divStep, 1);
    flush = 1'b1;
    #1;
    checkOutput("flush_step_low", divStep, 0);
    stepCycle();
    flush = 1'b0;
    checkOutput("flush_in_rdy", inRdy, 1);
    vldSeen = 0;
    repeat (70) begin
      if (outVld || divStep) vldSeen++;
      stepCycle();
    end
    checkOutput("flush_no_vld", vldSeen, 0);

    // Flush together with in_vld in IDLE: nothing is accepted.
    inVld = 1'b1;
    flush = 1'b1;
    stepCycle();
    inVld = 1'b0;
    flush = 1'b0;
    checkOutput("idle_flush_rdy", inRdy, 1);
    vldSeen = 0;
    repeat (5) begin
      stepCycle();
      if (divStep || !inRdy) vldSeen++;
    end
    checkOutput("idle_flush_idle", vldSeen, 0);

    // Backpressure: result held stable while out_rdy stays low.
    setOperands(1, 11'h3FF, 11'h3FF, 0, 0, 0, 0, 0);
    applyStimulus(lat, nstep);
    checkOutput("stall_latency", lat, 59);
    changes = 0;
    repeat (20) begin
      stepCycle();
      if (outExp !== 11'h3FE || !outVld || inRdy || outOf || outUf) changes++;
    end
    checkOutput("stall_changes", changes, 0);
    checkOutput("stall_exp", outExp, 11'h3FE);
    checkOutput("stall_in_rdy", inRdy, 0);
    releaseResult("stall");

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
